data_ram_responder: RTL
=======================

DATA_RAM_RESPONDER -- requirements
Module: data_ram_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12; byte-address width, depth = 2^(ADDR_WIDTH-2) words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32; word width, fixed 32 in this revision.
REQ-003 SHALL have one clock and a synchronous active-low reset.
REQ-004 SHALL have these ports:
  clk        in   1           rising-edge clock
  rst_n      in   1           synchronous active-low reset
  req_valid  in   1           initiator presents a request
  req_ready  out  1           responder accepts the request this cycle
  req_we     in   1           1 = write, 0 = read
  req_addr   in   ADDR_WIDTH  byte address
  req_wdata  in   32          write data
  req_wstrb  in   4           byte-lane write enables; bit i covers [8i+7:8i]
  rsp_valid  out  1           response present
  rsp_ready  in   1           initiator consumes the response
  rsp_rdata  out  32          read data; 0 for writes and errors
  rsp_err    out  1           access error flag

Function
REQ-005 SHALL accept a request on a cycle where req_valid & req_ready are both 1 (the transfer).
REQ-006 SHALL drive req_ready = !rsp_valid | rsp_ready (combinational, one-deep response stage).
REQ-007 SHALL implement two states: IDLE (rsp_valid=0) and RESP (rsp_valid=1).
REQ-008 IDLE->RESP on transfer; RESP->IDLE on rsp_ready with no new transfer; RESP->RESP on rsp_ready with a new transfer.
REQ-009 SHALL present the response exactly 1 cycle after the transfer; throughput is 1 request/cycle when rsp_ready is held 1.
REQ-010 Read: rsp_rdata SHALL be the full word at req_addr[ADDR_WIDTH-1:2] as stored before the transfer edge.
REQ-011 Write: SHALL update only lanes with req_wstrb[i]=1 at the transfer edge; rsp_rdata=0, rsp_err=0.
REQ-012 Write with req_wstrb=0 SHALL leave memory unchanged and still produce a response.
REQ-013 A read transferred in the cycle after a write to the same word SHALL return the written data.
REQ-014 While rsp_valid=1 and rsp_ready=0, rsp_rdata and rsp_err SHALL hold stable, req_ready SHALL be 0, and no memory write SHALL occur.
REQ-015 req_we, req_addr, req_wdata, req_wstrb SHALL be ignored when no transfer occurs.
REQ-016 Address bits above the word index do not exist; every address within ADDR_WIDTH is in range.

Reset
REQ-017 On rst_n=0 at a rising edge, SHALL set state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-018 A reset asserted mid-response SHALL drop the pending response without a retry.
REQ-019 Memory contents SHALL NOT be reset and SHALL NOT be written while rst_n=0.
REQ-020 req_ready SHALL be 0 while rst_n=0.

Configuration
REQ-021 Macro DATA_RAM_MISALIGN_CHECK_EN SHALL select misaligned-access checking.
REQ-022 With the macro defined, a transfer with req_addr[1:0]!=0 SHALL suppress any write and respond rsp_err=1 and rsp_rdata=0.
REQ-023 Without the macro, req_addr[1:0] SHALL be ignored and rsp_err SHALL be constant 0.

Verification
REQ-024 Write 0xDEADBEEF to 0x010 with wstrb=F, then read 0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0, each 1 cycle after its transfer.
REQ-025 After REQ-024, write 0x00001200 to 0x010 with wstrb=4'b0010, then read -> 0xDEAD12EF.
REQ-026 Back-to-back reads of 0x000, 0x004, 0x008 with rsp_ready=1 -> three consecutive rsp_valid cycles, req_ready held 1.
REQ-027 rsp_ready=0 for 3 cycles during a read response -> rsp_rdata stable, req_ready=0, and a held write request is not performed until acceptance.
REQ-028 Macro defined: write to 0x012 -> rsp_err=1, rdata 0, word 0x010 unchanged; macro undefined: same access writes word 0x010, rsp_err=0.
REQ-029 rst_n=0 for one cycle while rsp_valid=1 -> next cycle rsp_valid=0, rsp_rdata=0; the memory word previously written still reads back.

Source files
------------

// File: rtl/data_ram_responder.sv
// ============================================================================
// data_ram_responder
// ----------------------------------------------------------------------------
// Single-port word RAM behind a valid/ready request channel and a one-deep
// registered response channel. Every accepted request (read or write)
// produces exactly one response on the cycle after it is accepted. A new
// request can be accepted in the same cycle that the current response is
// consumed, so the block sustains one request per cycle while rsp_ready
// stays high.
//
// Configuration macro:
//   DATA_RAM_MISALIGN_CHECK_EN - when defined, any access whose byte address
//   is not word aligned is rejected: no write happens and the response
//   carries rsp_err=1 with rsp_rdata=0. When undefined, the two low address
//   bits are ignored and rsp_err is always 0.
//
// Parameters:
//   ADDR_WIDTH - byte-address width; the RAM holds 2^(ADDR_WIDTH-2) words
//   DATA_WIDTH - word width (32 in this revision)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset (memory is not cleared)
//   req_valid  in   initiator presents a request
//   req_ready  out  request accepted this cycle (valid & ready = transfer)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   byte address
//   req_wdata  in   write data
//   req_wstrb  in   byte-lane write enables, bit i covers [8i+7:8i]
//   rsp_valid  out  response present
//   rsp_ready  in   initiator consumes the response
//   rsp_rdata  out  read data, 0 for writes and errored accesses
//   rsp_err    out  access error flag
// ============================================================================
module data_ram_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err
);

    localparam int WORD_BITS = ADDR_WIDTH - 2;
    localparam int DEPTH     = 1 << WORD_BITS;
    localparam int LANES     = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic                   transfer;
    logic                   misaligned;
    logic                   write_en;
    logic [WORD_BITS-1:0]   word_idx;
    logic [DATA_WIDTH-1:0]  read_word;

    // The response stage is one deep: a new request can only enter when the
    // stage is empty or is being drained this very cycle. Holding ready low
    // during reset keeps any request (and any write) out while rst_n is low.
    assign req_ready = rst_n & (~rsp_valid | rsp_ready);
    assign transfer  = req_valid & req_ready;

    assign word_idx  = req_addr[ADDR_WIDTH-1:2];

`ifdef DATA_RAM_MISALIGN_CHECK_EN
    assign misaligned = |req_addr[1:0];
`else
    // Byte offset is irrelevant when alignment is not checked.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^req_addr[1:0];
    assign misaligned       = 1'b0;
`endif

    // A rejected (misaligned) access must never touch memory.
    assign write_en = transfer & req_we & ~misaligned;

    // Asynchronous read of the addressed word; the value captured into the
    // response register at the transfer edge is the pre-write content.
    assign read_word = mem[word_idx];

    // Memory array: no reset so it maps onto plain RAM, byte-lane writes.
    always_ff @(posedge clk) begin
        if (write_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (req_wstrb[i]) begin
                    mem[word_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response FSM. IDLE means the response stage is empty, RESP means it
    // holds a response. While a response is stalled (rsp_ready low) nothing
    // is assigned, so rdata/err hold and no transfer can occur.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= (req_we | misaligned) ? '0 : read_word;
                        rsp_err   <= misaligned;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        if (transfer) begin
                            // Back-to-back: replace the consumed response.
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= (req_we | misaligned) ? '0 : read_word;
                            rsp_err   <= misaligned;
                        end else begin
                            state     <= IDLE;
                            rsp_valid <= 1'b0;
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
